// File: rtl/ccip_if_pkg.sv
// CCI-P channel-1 request types used by the NLB write path.
// Field layout and encodings follow the CCI-P interface definition.
package ccip_if_pkg;

    typedef logic [511:0] t_ccip_clData;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

endpackage

// File: rtl/nlb_c1buf_pkg.sv
// Shared types for the channel-1 Tx buffer: drain state and FIFO entry.
package nlb_c1buf_pkg;
    import ccip_if_pkg::*;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } t_c1buf_state;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
    } t_c1buf_entry;

endpackage

// File: rtl/ccip_c1_sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read port.
// pop_data always shows the head entry; pop while empty is ignored, and a
// push while full is accepted only when a pop frees a slot in the same cycle.
module ccip_c1_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccip_c1_tx_buffer.sv
// CCI-P channel-1 write-request buffer between the NLB core and the
// interface register stage. Queues requests, drains them while c1TxAlmFull
// allows, and keeps multi-CL writes atomic once their first beat issues.
//
// Handshake: the core side has no ready; a request is taken whenever
// af_c1Tx_valid=1 at a rising edge and the FIFO has room (or frees a slot the
// same edge). af_c1Tx_almFull is the core's stop signal with ALMFULL_SLACK
// entries of headroom; pushes beyond that are dropped and flag overflow_err.
module ccip_c1_tx_buffer
    import ccip_if_pkg::*;
    import nlb_c1buf_pkg::*;
#(
    parameter int DEPTH_LOG2    = 6,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                  pClk,
    input  logic                  SoftReset,
    input  logic                  af_c1Tx_valid,
    input  t_ccip_c1_ReqMemHdr    af_c1Tx_hdr,
    input  logic [511:0]          af_c1Tx_data,
    output logic                  af_c1Tx_almFull,
    input  logic                  cp_c1TxAlmFull,
    output t_if_ccip_c1_Tx        cp_c1Tx,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow_err,
    output logic                  drain_state
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] SLACK_CNT = (DEPTH_LOG2+1)'(ALMFULL_SLACK);

    t_c1buf_state        state;
    logic [1:0]          beats_left;
    t_c1buf_entry        push_entry;
    t_c1buf_entry        head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push_ok;
    logic                starts_burst;
    logic [DEPTH_LOG2:0] count_next;
    logic [DEPTH_LOG2:0] free_next;

    assign push_entry = '{hdr: af_c1Tx_hdr, data: af_c1Tx_data};

    ccip_c1_sync_fifo #(
        .WIDTH      ($bits(t_c1buf_entry)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (pClk),
        .rst       (SoftReset),
        .push      (af_c1Tx_valid),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Inside a burst the remaining beats ignore c1TxAlmFull so the write stays atomic.
    assign pop = !fifo_empty && ((state == BURST) || !cp_c1TxAlmFull);

    assign push_ok     = af_c1Tx_valid && (!fifo_full || pop);
    assign drain_state = (state == BURST);

    // Only a sop beat of a 2-CL or 4-CL write opens a burst; fences never do.
    assign starts_burst = head.hdr.sop
                       && (head.hdr.cl_len != eCL_LEN_1)
                       && (head.hdr.req_type != eREQ_WRFENCE);

    // Occupancy after this edge, so almFull lines up with fifo_count.
    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = fifo_count - 1'b1;
        end
        free_next = FULL_CNT - count_next;
    end

    // Drain state machine: beats_left counts the beats still owed by an open burst.
    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            state      <= IDLE;
            beats_left <= 2'd0;
        end else if (pop) begin
            case (state)
                IDLE: begin
                    if (starts_burst) begin
                        beats_left <= head.hdr.cl_len;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    beats_left <= beats_left - 2'd1;
                    if (beats_left == 2'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: valid for one cycle per pop, hdr/data hold between pops.
    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            cp_c1Tx <= '0;
        end else begin
            cp_c1Tx.valid <= pop;
            if (pop) begin
                cp_c1Tx.hdr  <= head.hdr;
                cp_c1Tx.data <= head.data;
            end
        end
    end

    // Core-side almFull and the sticky overflow flag.
    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            af_c1Tx_almFull <= 1'b0;
            overflow_err    <= 1'b0;
        end else begin
            af_c1Tx_almFull <= (free_next <= SLACK_CNT);
            if (af_c1Tx_valid && !push_ok) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_c1_tx_buffer.sv
// Self-checking bench for ccip_c1_tx_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ccip_c1_tx_buffer;
    import ccip_if_pkg::*;
    import nlb_c1buf_pkg::*;

    localparam int DEPTH = 64;
    localparam int SLACK = 8;
    localparam int W     = $bits(t_c1buf_entry);

    logic               pClk = 1'b0;
    logic               SoftReset;
    logic               af_c1Tx_valid;
    t_ccip_c1_ReqMemHdr af_c1Tx_hdr;
    logic [511:0]       af_c1Tx_data;
    logic               af_c1Tx_almFull;
    logic               cp_c1TxAlmFull;
    t_if_ccip_c1_Tx     cp_c1Tx;
    logic [6:0]         fifo_count;
    logic               overflow_err;
    logic               drain_state;

    // ---------------- clock / reset ----------------
    always #5 pClk = ~pClk;

    ccip_c1_tx_buffer #(.DEPTH_LOG2(6), .ALMFULL_SLACK(SLACK)) dut (
        .pClk            (pClk),
        .SoftReset       (SoftReset),
        .af_c1Tx_valid   (af_c1Tx_valid),
        .af_c1Tx_hdr     (af_c1Tx_hdr),
        .af_c1Tx_data    (af_c1Tx_data),
        .af_c1Tx_almFull (af_c1Tx_almFull),
        .cp_c1TxAlmFull  (cp_c1TxAlmFull),
        .cp_c1Tx         (cp_c1Tx),
        .fifo_count      (fifo_count),
        .overflow_err    (overflow_err),
        .drain_state     (drain_state)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0]       exp_q[$];     // requests held in the buffer, oldest first
    int                 burst_owed;   // beats still owed by an issued multi-CL write
    logic               exp_valid;
    t_ccip_c1_ReqMemHdr exp_hdr;
    logic [511:0]       exp_data;
    logic               exp_ovf;
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 obs_beats;
    logic               rand_af = 1'b0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cl_count(input t_ccip_clLen len);
        if (len == eCL_LEN_4) return 4;
        if (len == eCL_LEN_2) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        burst_owed = 0;
        exp_valid  = 1'b0;
        exp_hdr    = '0;
        exp_data   = '0;
        exp_ovf    = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using the inputs now applied.
    task automatic model_edge();
        t_c1buf_entry e;
        bit take;
        bit accept;
        take   = (exp_q.size() > 0) && (burst_owed > 0 || !cp_c1TxAlmFull);
        accept = af_c1Tx_valid && (exp_q.size() < DEPTH || take);
        exp_valid = take;
        if (take) begin
            e = exp_q.pop_front();
            exp_hdr  = e.hdr;
            exp_data = e.data;
            if (burst_owed > 0)
                burst_owed--;
            else if (e.hdr.sop && e.hdr.req_type != eREQ_WRFENCE)
                burst_owed = cl_count(e.hdr.cl_len) - 1;
        end
        if (accept)
            exp_q.push_back({af_c1Tx_hdr, af_c1Tx_data});
        else if (af_c1Tx_valid)
            exp_ovf = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 512'(cp_c1Tx.valid), 512'(exp_valid));
        if (exp_valid) begin
            check({tag, ".hdr"},  512'(cp_c1Tx.hdr), 512'(exp_hdr));
            check({tag, ".data"}, cp_c1Tx.data, exp_data);
        end
        check({tag, ".count"}, 512'(fifo_count), 512'(exp_q.size()));
        check({tag, ".almfull"}, 512'(af_c1Tx_almFull), 512'((DEPTH - exp_q.size()) <= SLACK));
        check({tag, ".overflow"}, 512'(overflow_err), 512'(exp_ovf));
        check({tag, ".burst"}, 512'(drain_state), 512'(burst_owed > 0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"}, 512'(cp_c1Tx.valid), 512'(0));
        check({tag, ".hdr"}, 512'(cp_c1Tx.hdr), 512'(0));
        check({tag, ".data"}, cp_c1Tx.data, 512'(0));
        check({tag, ".count"}, 512'(fifo_count), 512'(0));
        check({tag, ".almfull"}, 512'(af_c1Tx_almFull), 512'(0));
        check({tag, ".overflow"}, 512'(overflow_err), 512'(0));
        check({tag, ".burst"}, 512'(drain_state), 512'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag);
        @(posedge pClk);
        model_edge();
        @(negedge pClk);
        if (cp_c1Tx.valid) obs_beats++;
        check_outputs(tag);
        if (rand_af) cp_c1TxAlmFull = ($urandom_range(0, 3) == 0);
    endtask

    function automatic t_ccip_c1_ReqMemHdr mk_hdr(input t_ccip_c1_req rt, input t_ccip_clLen len,
                                                  input logic sop, input logic [41:0] addr);
        t_ccip_c1_ReqMemHdr h;
        h          = '0;
        h.req_type = rt;
        h.cl_len   = len;
        h.sop      = sop;
        h.address  = addr;
        h.mdata    = 16'($urandom());
        return h;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic push(input string tag, input t_ccip_c1_ReqMemHdr h);
        af_c1Tx_valid = 1'b1;
        af_c1Tx_hdr   = h;
        af_c1Tx_data  = rand_data();
        step(tag);
        af_c1Tx_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        af_c1Tx_valid = 1'b0;
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Push all beats of one write: sop on the first beat, same cl_len on each.
    task automatic push_write(input string tag, input t_ccip_c1_req rt, input t_ccip_clLen len,
                              input logic [41:0] addr, input int max_gap);
        for (int b = 0; b < cl_count(len); b++) begin
            push(tag, mk_hdr(rt, len, (b == 0), addr + 42'(b)));
            if (max_gap > 0) idle(tag, $urandom_range(0, max_gap));
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 300;
        cp_c1TxAlmFull = 1'b0;
        while ((fifo_count != 0 || cp_c1Tx.valid) && budget > 0) begin
            step(tag);
            budget--;
        end
        check({tag, ".drain_timeout"}, 512'(budget == 0), 512'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        SoftReset      = 1'b1;
        af_c1Tx_valid  = 1'b0;
        af_c1Tx_hdr    = '0;
        af_c1Tx_data   = '0;
        cp_c1TxAlmFull = 1'b0;
        model_reset();
        repeat (2) @(negedge pClk);
        check_reset_state("reset");
        SoftReset = 1'b0;
        idle("post_reset", 2);

        // Single-CL pass-through, 2-edge latency
        obs_beats = 0;
        push("t1_push", mk_hdr(eREQ_WRLINE_I, eCL_LEN_1, 1'b1, 42'h100));
        check("t1.no_early_out", 512'(cp_c1Tx.valid), 512'(0));
        step("t1_out");
        check("t1.addr", 512'(cp_c1Tx.hdr.address), 512'(42'h100));
        idle("t1_idle", 2);
        check("t1.beats", 512'(obs_beats), 512'(1));
        check("t1.count", 512'(fifo_count), 512'(0));

        // almFull gating
        cp_c1TxAlmFull = 1'b1;
        obs_beats = 0;
        for (int i = 0; i < 5; i++) push("t2_push", mk_hdr(eREQ_WRLINE_M, eCL_LEN_1, 1'b1, 42'h200 + 42'(i)));
        idle("t2_hold", 3);
        check("t2.held_count", 512'(fifo_count), 512'(5));
        check("t2.held_beats", 512'(obs_beats), 512'(0));
        cp_c1TxAlmFull = 1'b0;
        idle("t2_drain", 7);
        check("t2.beats", 512'(obs_beats), 512'(5));

        // 4-CL atomicity with almFull raised after the first beat issues
        obs_beats = 0;
        push("t3_b0", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b1, 42'h300));
        push("t3_b1", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h301));
        cp_c1TxAlmFull = 1'b1;
        push("t3_b2", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h302));
        push("t3_b3", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h303));
        push("t3_single", mk_hdr(eREQ_WRLINE_I, eCL_LEN_1, 1'b1, 42'h310));
        idle("t3_hold", 4);
        check("t3.burst_beats", 512'(obs_beats), 512'(4));
        check("t3.single_held", 512'(fifo_count), 512'(1));
        cp_c1TxAlmFull = 1'b0;
        idle("t3_release", 3);
        check("t3.total_beats", 512'(obs_beats), 512'(5));

        // Mid-burst underflow: bubble while state stays in the burst
        obs_beats = 0;
        push("t4_b0", mk_hdr(eREQ_WRLINE_I, eCL_LEN_2, 1'b1, 42'h400));
        idle("t4_gap", 2);
        check("t4.in_burst", 512'(drain_state), 512'(1));
        push("t4_b1", mk_hdr(eREQ_WRLINE_I, eCL_LEN_2, 1'b0, 42'h401));
        idle("t4_tail", 3);
        check("t4.beats", 512'(obs_beats), 512'(2));
        check("t4.idle", 512'(drain_state), 512'(0));

        // Fill to full and overflow
        cp_c1TxAlmFull = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push("t5_fill", mk_hdr(eREQ_WRLINE_I, eCL_LEN_1, 1'b1, 42'h1000 + 42'(i)));
            check("t5.almfull_at_count", 512'(af_c1Tx_almFull), 512'(i + 1 >= DEPTH - SLACK));
        end
        push("t5_over", mk_hdr(eREQ_WRLINE_I, eCL_LEN_1, 1'b1, 42'hdead));
        check("t5.overflow", 512'(overflow_err), 512'(1));
        check("t5.count_full", 512'(fifo_count), 512'(DEPTH));
        drain("t5_drain");

        // Async reset in the middle of a 4-CL burst
        push("t6_b0", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b1, 42'h600));
        push("t6_b1", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h601));
        push("t6_b2", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h602));
        push("t6_b3", mk_hdr(eREQ_WRLINE_I, eCL_LEN_4, 1'b0, 42'h603));
        check("t6.beat2_out", 512'(cp_c1Tx.hdr.address), 512'(42'h602));
        #2 SoftReset = 1'b1;
        #1;
        check_reset_state("t6_async");
        model_reset();
        @(posedge pClk);
        @(negedge pClk);
        SoftReset = 1'b0;
        idle("t6_after", 2);
        push("t6_new", mk_hdr(eREQ_WRLINE_I, eCL_LEN_1, 1'b1, 42'h700));
        step("t6_new_out");
        check("t6.new_addr", 512'(cp_c1Tx.hdr.address), 512'(42'h700));
        idle("t6_idle", 2);

        // Randomized traffic with random c1TxAlmFull
        rand_af = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int kind;
            t_ccip_clLen len;
            t_ccip_c1_req rt;
            kind = $urandom_range(0, 3);
            len  = (kind == 1) ? eCL_LEN_2 : (kind == 2) ? eCL_LEN_4 : eCL_LEN_1;
            rt   = (kind == 3) ? eREQ_WRFENCE : eREQ_WRLINE_I;
            while (af_c1Tx_almFull) idle("rnd_wait", 1);
            push_write("rnd", rt, len, 42'($urandom()), 2);
        end
        rand_af = 1'b0;
        drain("rnd_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
